// File: rtl/uctl_cmd_pkg.sv
// Shared cmdIf arbiter definitions: FSM state encodings, default field widths
// and grant-vector helpers.
package uctl_cmd_pkg;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;
  localparam int NUM_REQ    = 2;

  localparam logic [1:0] ARB_IDLE = 2'b00;
  localparam logic [1:0] ARB_OWN  = 2'b01;

  typedef logic [NUM_REQ-1:0] gnt_t;

  // Index of the owner in a one-hot two-bit grant vector.
  function automatic logic gnt_idx(input gnt_t g);
    return g[1];
  endfunction

endpackage

// File: rtl/uctl_rr_arb2.sv
// Two-way picker: round-robin pointer (or fixed priority to requester 0)
// producing a one-hot selection among the pending requesters.
module uctl_rr_arb2
  import uctl_cmd_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_swRst,
  input  gnt_t i_pend,
  input  logic i_upd,
  input  logic i_ownerIdx,
  output gnt_t o_pick
);

  logic r_ptr;

  // After a transaction ends the pointer favours the requester that did not own the bus.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (i_swRst) begin
      r_ptr <= 1'b0;
    end else if (i_upd) begin
      r_ptr <= ~i_ownerIdx;
    end
  end

  always_comb begin
    o_pick = i_pend;
    if (i_pend == 2'b11) begin
      if ((FIXED_PRI != 0) || !r_ptr) begin
        o_pick = 2'b01;
      end else begin
        o_pick = 2'b10;
      end
    end
  end

endmodule

// File: rtl/uctl_cmd_if_arb.sv
// Two-requester cmdIf arbiter: grant FSM, stall watchdog and owner-gated
// forwarding of command, write-beat and read-beat handshakes.
module uctl_cmd_if_arb
  import uctl_cmd_pkg::*;
#(
  parameter int ADDR_W    = CMD_ADDR_W,
  parameter int DATA_W    = CMD_DATA_W,
  parameter int FIXED_PRI = 0,
  parameter int TO_CYC    = 256
) (
  input  logic              i_hClk,
  input  logic              i_hReset,
  input  logic              i_swRst,
  input  logic              i_m0_trEn,
  input  logic              i_m0_req,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic              i_m0_wrRd,
  output logic              o_m0_ack,
  input  logic              i_m0_wrData_req,
  input  logic [DATA_W-1:0] i_m0_wrData,
  output logic              o_m0_wrData_ack,
  input  logic              i_m0_rdData_req,
  output logic [DATA_W-1:0] o_m0_rdData,
  output logic              o_m0_rdData_ack,
  input  logic              i_m1_trEn,
  input  logic              i_m1_req,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic              i_m1_wrRd,
  output logic              o_m1_ack,
  input  logic              i_m1_wrData_req,
  input  logic [DATA_W-1:0] i_m1_wrData,
  output logic              o_m1_wrData_ack,
  input  logic              i_m1_rdData_req,
  output logic [DATA_W-1:0] o_m1_rdData,
  output logic              o_m1_rdData_ack,
  output logic              o_s_trEn,
  output logic              o_s_req,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic              o_s_wrRd,
  output logic              o_s_wrData_req,
  output logic [DATA_W-1:0] o_s_wrData,
  output logic              o_s_rdData_req,
  input  logic              i_s_ack,
  input  logic              i_s_wrData_ack,
  input  logic [DATA_W-1:0] i_s_rdData,
  input  logic              i_s_rdData_ack,
  output logic [1:0]        o_arb_gnt,
  output logic              o_arb_timeout
);

  localparam int              WD_W   = $clog2(TO_CYC);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TO_CYC - 1);

  logic [1:0]      r_state;
  gnt_t            r_gnt;
  logic [WD_W-1:0] r_wdCnt;
  logic            r_timeout;

  gnt_t w_pend;
  gnt_t w_pick;
  logic w_sel0;
  logic w_sel1;
  logic w_ownTrEn;
  logic w_anyAck;
  logic w_wdExp;
  logic w_upd;

  assign w_pend    = {i_m1_trEn & i_m1_req, i_m0_trEn & i_m0_req};
  assign w_sel0    = r_gnt[0];
  assign w_sel1    = r_gnt[1];
  assign w_ownTrEn = (w_sel0 & i_m0_trEn) | (w_sel1 & i_m1_trEn);
  assign w_anyAck  = i_s_ack | i_s_wrData_ack | i_s_rdData_ack;
  // A handshake completing in the final cycle counts as progress, not a stall.
  assign w_wdExp   = (r_wdCnt == WD_MAX) && !w_anyAck;
  assign w_upd     = (r_state == ARB_OWN) && (!w_ownTrEn || w_wdExp);

  uctl_rr_arb2 #(
    .FIXED_PRI(FIXED_PRI)
  ) u_pick (
    .i_clk     (i_hClk),
    .i_rst     (i_hReset),
    .i_swRst   (i_swRst),
    .i_pend    (w_pend),
    .i_upd     (w_upd),
    .i_ownerIdx(gnt_idx(r_gnt)),
    .o_pick    (w_pick)
  );

  // Owner release takes precedence over watchdog expiry, so no timeout pulse then.
  always_ff @(posedge i_hClk or posedge i_hReset) begin
    if (i_hReset) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= '0;
      r_wdCnt   <= '0;
      r_timeout <= 1'b0;
    end else if (i_swRst) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= '0;
      r_wdCnt   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (|w_pend) begin
            r_state <= ARB_OWN;
            r_gnt   <= w_pick;
            r_wdCnt <= '0;
          end
        end
        ARB_OWN: begin
          if (!w_ownTrEn) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
          end else if (w_wdExp) begin
            r_state   <= ARB_IDLE;
            r_gnt     <= '0;
            r_timeout <= 1'b1;
          end else if (w_anyAck) begin
            r_wdCnt <= '0;
          end else if (r_wdCnt != WD_MAX) begin
            r_wdCnt <= r_wdCnt + WD_W'(1);
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  // Everything below is gated by the registered grant; idle means all zero.
  assign o_s_trEn       = (w_sel0 & i_m0_trEn) | (w_sel1 & i_m1_trEn);
  assign o_s_req        = (w_sel0 & i_m0_req) | (w_sel1 & i_m1_req);
  assign o_s_addr       = ({ADDR_W{w_sel0}} & i_m0_addr) | ({ADDR_W{w_sel1}} & i_m1_addr);
  assign o_s_wrRd       = (w_sel0 & i_m0_wrRd) | (w_sel1 & i_m1_wrRd);
  assign o_s_wrData_req = (w_sel0 & i_m0_wrData_req) | (w_sel1 & i_m1_wrData_req);
  assign o_s_wrData     = ({DATA_W{w_sel0}} & i_m0_wrData) | ({DATA_W{w_sel1}} & i_m1_wrData);
  assign o_s_rdData_req = (w_sel0 & i_m0_rdData_req) | (w_sel1 & i_m1_rdData_req);

  assign o_m0_ack        = w_sel0 & i_s_ack;
  assign o_m0_wrData_ack = w_sel0 & i_s_wrData_ack;
  assign o_m0_rdData_ack = w_sel0 & i_s_rdData_ack;
  assign o_m0_rdData     = {DATA_W{w_sel0}} & i_s_rdData;
  assign o_m1_ack        = w_sel1 & i_s_ack;
  assign o_m1_wrData_ack = w_sel1 & i_s_wrData_ack;
  assign o_m1_rdData_ack = w_sel1 & i_s_rdData_ack;
  assign o_m1_rdData     = {DATA_W{w_sel1}} & i_s_rdData;

  assign o_arb_gnt     = r_gnt;
  assign o_arb_timeout = r_timeout;

endmodule

// File: tb/tb_uctl_cmd_if_arb.sv
// Self-checking bench for uctl_cmd_if_arb: a round-robin and a fixed-priority
// instance share stimulus; grant order is predicted into a scoreboard queue.
module tb_uctl_cmd_if_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct {
    logic [1:0]    gnt;
    logic [AW-1:0] addr;
  } grantExp_t;

  logic clk = 1'b0;
  logic hReset, swRst;
  logic m0TrEn, m0Req, m0WrRd, m0WrDataReq, m0RdDataReq;
  logic m1TrEn, m1Req, m1WrRd, m1WrDataReq, m1RdDataReq;
  logic [AW-1:0] m0Addr, m1Addr;
  logic [DW-1:0] m0WrData, m1WrData, sRdData;
  logic sAck, sWrDataAck, sRdDataAck;

  logic rrM0Ack, rrM0WrDataAck, rrM0RdDataAck, rrM1Ack, rrM1WrDataAck, rrM1RdDataAck;
  logic [DW-1:0] rrM0RdData, rrM1RdData, rrSWrData;
  logic rrSTrEn, rrSReq, rrSWrRd, rrSWrDataReq, rrSRdDataReq, rrTimeout;
  logic [AW-1:0] rrSAddr;
  logic [1:0] rrGnt;

  logic fpM0Ack, fpM0WrDataAck, fpM0RdDataAck, fpM1Ack, fpM1WrDataAck, fpM1RdDataAck;
  logic [DW-1:0] fpM0RdData, fpM1RdData, fpSWrData;
  logic fpSTrEn, fpSReq, fpSWrRd, fpSWrDataReq, fpSRdDataReq, fpTimeout;
  logic [AW-1:0] fpSAddr;
  logic [1:0] fpGnt;

  grantExp_t expQ[$];
  int errors = 0;
  int checks = 0;
  logic tbPtr;

  always #5 clk = ~clk;

  uctl_cmd_if_arb #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(0), .TO_CYC(TO)) dutRr (
    .i_hClk(clk), .i_hReset(hReset), .i_swRst(swRst),
    .i_m0_trEn(m0TrEn), .i_m0_req(m0Req), .i_m0_addr(m0Addr), .i_m0_wrRd(m0WrRd),
    .o_m0_ack(rrM0Ack), .i_m0_wrData_req(m0WrDataReq), .i_m0_wrData(m0WrData),
    .o_m0_wrData_ack(rrM0WrDataAck), .i_m0_rdData_req(m0RdDataReq),
    .o_m0_rdData(rrM0RdData), .o_m0_rdData_ack(rrM0RdDataAck),
    .i_m1_trEn(m1TrEn), .i_m1_req(m1Req), .i_m1_addr(m1Addr), .i_m1_wrRd(m1WrRd),
    .o_m1_ack(rrM1Ack), .i_m1_wrData_req(m1WrDataReq), .i_m1_wrData(m1WrData),
    .o_m1_wrData_ack(rrM1WrDataAck), .i_m1_rdData_req(m1RdDataReq),
    .o_m1_rdData(rrM1RdData), .o_m1_rdData_ack(rrM1RdDataAck),
    .o_s_trEn(rrSTrEn), .o_s_req(rrSReq), .o_s_addr(rrSAddr), .o_s_wrRd(rrSWrRd),
    .o_s_wrData_req(rrSWrDataReq), .o_s_wrData(rrSWrData), .o_s_rdData_req(rrSRdDataReq),
    .i_s_ack(sAck), .i_s_wrData_ack(sWrDataAck), .i_s_rdData(sRdData),
    .i_s_rdData_ack(sRdDataAck), .o_arb_gnt(rrGnt), .o_arb_timeout(rrTimeout)
  );

  uctl_cmd_if_arb #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(1), .TO_CYC(TO)) dutFp (
    .i_hClk(clk), .i_hReset(hReset), .i_swRst(swRst),
    .i_m0_trEn(m0TrEn), .i_m0_req(m0Req), .i_m0_addr(m0Addr), .i_m0_wrRd(m0WrRd),
    .o_m0_ack(fpM0Ack), .i_m0_wrData_req(m0WrDataReq), .i_m0_wrData(m0WrData),
    .o_m0_wrData_ack(fpM0WrDataAck), .i_m0_rdData_req(m0RdDataReq),
    .o_m0_rdData(fpM0RdData), .o_m0_rdData_ack(fpM0RdDataAck),
    .i_m1_trEn(m1TrEn), .i_m1_req(m1Req), .i_m1_addr(m1Addr), .i_m1_wrRd(m1WrRd),
    .o_m1_ack(fpM1Ack), .i_m1_wrData_req(m1WrDataReq), .i_m1_wrData(m1WrData),
    .o_m1_wrData_ack(fpM1WrDataAck), .i_m1_rdData_req(m1RdDataReq),
    .o_m1_rdData(fpM1RdData), .o_m1_rdData_ack(fpM1RdDataAck),
    .o_s_trEn(fpSTrEn), .o_s_req(fpSReq), .o_s_addr(fpSAddr), .o_s_wrRd(fpSWrRd),
    .o_s_wrData_req(fpSWrDataReq), .o_s_wrData(fpSWrData), .o_s_rdData_req(fpSRdDataReq),
    .i_s_ack(sAck), .i_s_wrData_ack(sWrDataAck), .i_s_rdData(sRdData),
    .i_s_rdData_ack(sRdDataAck), .o_arb_gnt(fpGnt), .o_arb_timeout(fpTimeout)
  );

  // Reference choice of winner given pending requesters, mode and pointer.
  function automatic logic [1:0] predictGnt(input logic [1:0] pend, input logic fixed,
                                            input logic ptr);
    if (pend == 2'b11) return (fixed || !ptr) ? 2'b01 : 2'b10;
    return pend;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clearInputs();
    m0TrEn = 0; m0Req = 0; m0WrRd = 0; m0WrDataReq = 0; m0RdDataReq = 0;
    m1TrEn = 0; m1Req = 0; m1WrRd = 0; m1WrDataReq = 0; m1RdDataReq = 0;
    m0Addr = '0; m1Addr = '0; m0WrData = '0; m1WrData = '0; sRdData = '0;
    sAck = 0; sWrDataAck = 0; sRdDataAck = 0; swRst = 0;
  endtask

  task automatic resetDut();
    hReset = 1'b1;
    clearInputs();
    tick();
    tick();
    hReset = 1'b0;
    tbPtr = 1'b0;
    expQ.delete();
    tick();
  endtask

  // Push the expected winner and the address it will forward.
  task automatic pushExp(input logic [1:0] g);
    grantExp_t e;
    e.gnt  = g;
    e.addr = g[1] ? m1Addr : m0Addr;
    expQ.push_back(e);
  endtask

  task automatic test_reset();
    hReset = 1'b1;
    clearInputs();
    m0TrEn = 1; m0Req = 1; m1TrEn = 1; m1Req = 1; sAck = 1;
    tick();
    tick();
    checks++;
    if (rrGnt !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_gnt: got %b expected 00", rrGnt);
    end
    checks++;
    if ({rrSTrEn, rrSReq, rrTimeout, rrM0Ack, rrM1Ack} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000",
               {rrSTrEn, rrSReq, rrTimeout, rrM0Ack, rrM1Ack});
    end
    checks++;
    if (fpGnt !== 2'b00 || fpSTrEn !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_fp: got gnt=%b trEn=%b expected 00/0", fpGnt, fpSTrEn);
    end
    hReset = 1'b0;
    clearInputs();
    sAck = 1; sWrDataAck = 1; sRdDataAck = 1;
    #1;
    checks++;
    if ({rrM0Ack, rrM1Ack, rrM0WrDataAck, rrM1WrDataAck, rrM0RdDataAck, rrM1RdDataAck} !== 6'b0) begin
      errors++; $display("[TB] FAIL idle_ack_drop: got nonzero ack expected 000000");
    end
    clearInputs();
    tick();
  endtask

  task automatic test_single_write();
    grantExp_t e;
    resetDut();
    m0TrEn = 1; m0Req = 1; m0Addr = 32'h0000_0010; m0WrRd = 1;
    pushExp(predictGnt(2'b01, 1'b0, tbPtr));
    #1;
    checks++;
    if (rrGnt !== 2'b00 || rrSReq !== 1'b0) begin
      errors++; $display("[TB] FAIL write_latency: got gnt=%b req=%b expected 00/0", rrGnt, rrSReq);
    end
    tick();
    e = expQ.pop_front();
    checks++;
    if (rrGnt !== e.gnt || rrSAddr !== e.addr || rrSReq !== 1'b1 || rrSWrRd !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_grant: got gnt=%b addr=%h req=%b wr=%b expected %b/%h/1/1",
               rrGnt, rrSAddr, rrSReq, rrSWrRd, e.gnt, e.addr);
    end
    tick();
    sAck = 1;
    #1;
    checks++;
    if (rrM0Ack !== 1'b1 || rrM1Ack !== 1'b0) begin
      errors++; $display("[TB] FAIL write_ack_route: got m0=%b m1=%b expected 1/0", rrM0Ack, rrM1Ack);
    end
    tick();
    sAck = 0; m0Req = 0;
    for (int b = 0; b < 3; b++) begin
      m0WrDataReq = 1; m0WrData = 32'hA000_0000 + b; sWrDataAck = 1;
      #1;
      checks++;
      if (rrSWrData !== 32'hA000_0000 + b || rrSWrDataReq !== 1'b1 ||
          rrM0WrDataAck !== 1'b1 || rrM1WrDataAck !== 1'b0) begin
        errors++;
        $display("[TB] FAIL write_beat%0d: got data=%h req=%b ack0=%b ack1=%b expected %h/1/1/0",
                 b, rrSWrData, rrSWrDataReq, rrM0WrDataAck, rrM1WrDataAck, 32'hA000_0000 + b);
      end
      tick();
    end
    m0WrDataReq = 0; sWrDataAck = 0; m0TrEn = 0;
    #1;
    checks++;
    if (rrGnt !== 2'b01 || rrSTrEn !== 1'b0) begin
      errors++; $display("[TB] FAIL write_trEn_fall: got gnt=%b trEn=%b expected 01/0", rrGnt, rrSTrEn);
    end
    tick();
    checks++;
    if (rrGnt !== 2'b00) begin
      errors++; $display("[TB] FAIL write_release: got %b expected 00", rrGnt);
    end
  endtask

  task automatic test_round_robin();
    grantExp_t e;
    int w;
    logic ownIdx;
    logic [1:0] pend;
    resetDut();
    m0TrEn = 1; m0Req = 1; m0Addr = 32'h100;
    m1TrEn = 1; m1Req = 1; m1Addr = 32'h200; m1WrRd = 1;
    pushExp(predictGnt(2'b11, 1'b0, tbPtr));
    for (int round = 0; round < 3; round++) begin
      w = 0;
      do begin tick(); w++; end while (rrGnt === 2'b00 && w < 4);
      checks++;
      if (w != 1 || expQ.size() == 0) begin
        errors++; $display("[TB] FAIL rr_latency%0d: got %0d cycles expected 1", round, w);
        if (rrGnt === 2'b00 || expQ.size() == 0) return;
      end
      e = expQ.pop_front();
      checks++;
      if (rrGnt !== e.gnt || rrSAddr !== e.addr) begin
        errors++;
        $display("[TB] FAIL rr_order%0d: got gnt=%b addr=%h expected %b/%h",
                 round, rrGnt, rrSAddr, e.gnt, e.addr);
      end
      sAck = 1;
      #1;
      checks++;
      if ({rrM1Ack, rrM0Ack} !== e.gnt) begin
        errors++; $display("[TB] FAIL rr_ack%0d: got %b expected %b", round, {rrM1Ack, rrM0Ack}, e.gnt);
      end
      tick();
      sAck = 0;
      ownIdx = e.gnt[1];
      if (ownIdx) begin m1TrEn = 0; m1Req = 0; end
      else begin m0TrEn = 0; m0Req = 0; end
      tbPtr = ~ownIdx;
      tick();
      checks++;
      if (rrGnt !== 2'b00 || rrSTrEn !== 1'b0) begin
        errors++; $display("[TB] FAIL rr_bubble%0d: got gnt=%b trEn=%b expected 00/0", round, rrGnt, rrSTrEn);
      end
      if (round == 0) begin m0TrEn = 1; m0Req = 1; m0Addr = 32'h104; end
      pend = {m1TrEn & m1Req, m0TrEn & m0Req};
      if (pend != 2'b00) pushExp(predictGnt(pend, 1'b0, tbPtr));
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++; $display("[TB] FAIL rr_leftover: got %0d expected 0", expQ.size());
    end
    clearInputs();
    tick();
  endtask

  task automatic test_fixed_priority();
    grantExp_t e;
    int w;
    logic [1:0] pend;
    resetDut();
    m0TrEn = 1; m0Req = 1; m0Addr = 32'h110;
    m1TrEn = 1; m1Req = 1; m1Addr = 32'h210;
    pushExp(predictGnt(2'b11, 1'b1, tbPtr));
    for (int round = 0; round < 4; round++) begin
      w = 0;
      do begin tick(); w++; end while (fpGnt === 2'b00 && w < 4);
      checks++;
      if (w != 1 || expQ.size() == 0) begin
        errors++; $display("[TB] FAIL fp_latency%0d: got %0d cycles expected 1", round, w);
        if (fpGnt === 2'b00 || expQ.size() == 0) return;
      end
      e = expQ.pop_front();
      checks++;
      if (fpGnt !== e.gnt || fpSAddr !== e.addr) begin
        errors++;
        $display("[TB] FAIL fp_order%0d: got gnt=%b addr=%h expected %b/%h",
                 round, fpGnt, fpSAddr, e.gnt, e.addr);
      end
      if (e.gnt[1]) begin m1TrEn = 0; m1Req = 0; end
      else begin m0TrEn = 0; m0Req = 0; end
      tick();
      if (round < 2) begin m0TrEn = 1; m0Req = 1; m0Addr = 32'h120 + round; end
      pend = {m1TrEn & m1Req, m0TrEn & m0Req};
      if (pend != 2'b00) pushExp(predictGnt(pend, 1'b1, tbPtr));
    end
    clearInputs();
    tick();
  endtask

  task automatic test_timeout();
    grantExp_t e;
    int cyc;
    resetDut();
    m1TrEn = 1; m1Req = 1; m1Addr = 32'h300;
    pushExp(predictGnt(2'b01 << 1, 1'b0, tbPtr));
    tick();
    e = expQ.pop_front();
    checks++;
    if (rrGnt !== e.gnt || rrSAddr !== e.addr) begin
      errors++; $display("[TB] FAIL to_grant: got gnt=%b addr=%h expected %b/%h", rrGnt, rrSAddr, e.gnt, e.addr);
    end
    m0TrEn = 1; m0Req = 1; m0Addr = 32'h400;
    cyc = 0;
    do begin tick(); cyc++; end while (rrTimeout !== 1'b1 && cyc < 16);
    checks++;
    if (cyc != TO || rrGnt !== 2'b00) begin
      errors++; $display("[TB] FAIL to_expiry: got cycle=%0d gnt=%b expected %0d/00", cyc, rrGnt, TO);
    end
    tbPtr = 1'b0;
    pushExp(predictGnt(2'b11, 1'b0, tbPtr));
    tick();
    e = expQ.pop_front();
    checks++;
    if (rrGnt !== e.gnt || rrSAddr !== e.addr || rrTimeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_next_grant: got gnt=%b addr=%h to=%b expected %b/%h/0",
               rrGnt, rrSAddr, rrTimeout, e.gnt, e.addr);
    end
    clearInputs();
    tick();
  endtask

  task automatic test_swrst();
    grantExp_t e;
    resetDut();
    m0TrEn = 1; m0Req = 1; m0WrRd = 0; m0Addr = 32'h600;
    pushExp(predictGnt(2'b01, 1'b0, tbPtr));
    tick();
    e = expQ.pop_front();
    checks++;
    if (rrGnt !== e.gnt || rrSAddr !== e.addr || rrSWrRd !== 1'b0) begin
      errors++; $display("[TB] FAIL sw_grant: got gnt=%b addr=%h expected %b/%h", rrGnt, rrSAddr, e.gnt, e.addr);
    end
    sAck = 1;
    tick();
    sAck = 0; m0Req = 0; m0RdDataReq = 1; sRdData = 32'hDEAD_BEEF; sRdDataAck = 1;
    #1;
    checks++;
    if (rrSRdDataReq !== 1'b1 || rrM0RdData !== 32'hDEAD_BEEF || rrM0RdDataAck !== 1'b1 ||
        rrM1RdData !== 32'h0 || rrM1RdDataAck !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sw_read_beat: got req=%b d0=%h a0=%b d1=%h a1=%b expected 1/deadbeef/1/0/0",
               rrSRdDataReq, rrM0RdData, rrM0RdDataAck, rrM1RdData, rrM1RdDataAck);
    end
    swRst = 1;
    tick();
    checks++;
    if (rrGnt !== 2'b00 || rrSTrEn !== 1'b0 || rrSRdDataReq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sw_drop: got gnt=%b trEn=%b rdReq=%b expected 00/0/0", rrGnt, rrSTrEn, rrSRdDataReq);
    end
    swRst = 0; m0TrEn = 0; m0RdDataReq = 0; sRdDataAck = 0;
    m1TrEn = 1; m1Req = 1; m1Addr = 32'h700;
    tbPtr = 1'b0;
    pushExp(predictGnt(2'b10, 1'b0, tbPtr));
    tick();
    e = expQ.pop_front();
    checks++;
    if (rrGnt !== e.gnt || rrSAddr !== e.addr) begin
      errors++; $display("[TB] FAIL sw_regrant: got gnt=%b addr=%h expected %b/%h", rrGnt, rrSAddr, e.gnt, e.addr);
    end
    clearInputs();
    tick();
  endtask

  task automatic test_release_at_expiry();
    grantExp_t e;
    int pulses;
    resetDut();
    m0TrEn = 1; m0Req = 1; m0Addr = 32'h500;
    pushExp(predictGnt(2'b01, 1'b0, tbPtr));
    tick();
    e = expQ.pop_front();
    checks++;
    if (rrGnt !== e.gnt || rrSAddr !== e.addr) begin
      errors++; $display("[TB] FAIL rx_grant: got gnt=%b addr=%h expected %b/%h", rrGnt, rrSAddr, e.gnt, e.addr);
    end
    pulses = 0;
    for (int c = 0; c < TO - 1; c++) begin
      tick();
      if (rrTimeout === 1'b1) pulses++;
    end
    m0TrEn = 0; m0Req = 0;
    tick();
    if (rrTimeout === 1'b1) pulses++;
    checks++;
    if (rrGnt !== 2'b00) begin
      errors++; $display("[TB] FAIL rx_release: got %b expected 00", rrGnt);
    end
    tick();
    if (rrTimeout === 1'b1) pulses++;
    checks++;
    if (pulses != 0) begin
      errors++; $display("[TB] FAIL rx_no_timeout: got %0d pulses expected 0", pulses);
    end
  endtask

  initial begin
    hReset = 1'b1;
    clearInputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_swrst();
    test_release_at_expiry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
